// File: rtl/eip_seq_pkg.sv
// Shared types and constants for the EIP sequencer.
// Holds the phase state enum, EIP write codes and legal instruction lengths.
package eip_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        UPDATE,
        HALT
    } state_t;

    localparam logic [3:0] RW_JMP_ABS = 4'h4;
    localparam logic [3:0] RW_JMP_REL = 4'h5;

    localparam logic [3:0] LEN_1 = 4'd1;
    localparam logic [3:0] LEN_2 = 4'd2;
    localparam logic [3:0] LEN_4 = 4'd4;

    function automatic logic len_legal(input logic [3:0] n);
        return (n == LEN_1) || (n == LEN_2) || (n == LEN_4);
    endfunction

endpackage

// File: rtl/eip_next_calc.sv
// Combinational next-EIP select: sequential advance, absolute jump, or
// (with JMP_REL_EN defined) relative jump past the current instruction.
// Ports: eip, len, code, write_data in; next_eip out.
module eip_next_calc
    import eip_seq_pkg::*;
(
    input  logic [31:0] eip,
    input  logic [3:0]  len,
    input  logic [3:0]  code,
    input  logic [31:0] write_data,
    output logic [31:0] next_eip
);

    logic [31:0] seq_eip;

    // Wraps modulo 2^32 by construction.
    assign seq_eip = eip + {28'd0, len};

    always_comb begin
        next_eip = seq_eip;
        if (code == RW_JMP_ABS) begin
            next_eip = write_data;
        end
`ifdef JMP_REL_EN
        else if (code == RW_JMP_REL) begin
            next_eip = seq_eip + write_data;
        end
`endif
    end

endmodule

// File: rtl/eip_sequencer.sv
// Single-clock instruction sequencer owning EIP: FETCH/DECODE/EXEC/UPDATE.
// Ports: clock, reset (sync, active-high), run, halt_req; fetch req/addr/ack/data;
// instr, decode_en, num_of_ope; exec_en, exec_done; read_or_write, write_data;
// retire, eip, fault, halted. Optional macro JMP_REL_EN enables code 4'h5 jumps.
module eip_sequencer
    import eip_seq_pkg::*;
#(
    parameter logic [31:0] RESET_EIP = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        halt_req,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    output logic [31:0] instr,
    output logic        decode_en,
    input  logic [3:0]  num_of_ope,
    output logic        exec_en,
    input  logic        exec_done,
    input  logic [3:0]  read_or_write,
    input  logic [31:0] write_data,
    output logic        retire,
    output logic [31:0] eip,
    output logic        fault,
    output logic        halted
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] eip_q;
    logic [31:0] instr_q;
    logic [3:0]  len_q;
    logic        fault_q;
    logic [31:0] next_eip;

    eip_next_calc u_next (
        .eip        (eip_q),
        .len        (len_q),
        .code       (read_or_write),
        .write_data (write_data),
        .next_eip   (next_eip)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fetch_req = 1'b0;
        decode_en = 1'b0;
        exec_en   = 1'b0;
        retire    = 1'b0;
        halted    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                fetch_req = 1'b1;
                if (fetch_ack) state_d = DECODE;
            end
            DECODE: begin
                decode_en = 1'b1;
                state_d   = len_legal(num_of_ope) ? EXEC : HALT;
            end
            EXEC: begin
                exec_en = 1'b1;
                if (exec_done) state_d = UPDATE;
            end
            UPDATE: begin
                retire  = 1'b1;
                state_d = halt_req ? HALT : FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            eip_q   <= RESET_EIP;
            instr_q <= 32'd0;
            len_q   <= 4'd0;
            fault_q <= 1'b0;
        end else begin
            if (state_q == FETCH && fetch_ack) begin
                instr_q <= fetch_data;
            end
            if (state_q == DECODE) begin
                len_q <= num_of_ope;
                if (!len_legal(num_of_ope)) fault_q <= 1'b1;
            end
            if (state_q == UPDATE) begin
                eip_q <= next_eip;
            end
        end
    end

    assign fetch_addr = eip_q;
    assign eip        = eip_q;
    assign instr      = instr_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_eip_sequencer.sv
// Self-checking bench for eip_sequencer: directed and randomized instructions
// checked against a simple arithmetic EIP model.
module tb_eip_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic        halt_req;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_data;
    logic [31:0] instr;
    logic        decode_en;
    logic [3:0]  num_of_ope;
    logic        exec_en;
    logic        exec_done;
    logic [3:0]  read_or_write;
    logic [31:0] write_data;
    logic        retire;
    logic [31:0] eip;
    logic        fault;
    logic        halted;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] eip_m;

    eip_sequencer #(.RESET_EIP(32'h00000000)) dut (
        .clock         (clock),
        .reset         (reset),
        .run           (run),
        .halt_req      (halt_req),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_ack     (fetch_ack),
        .fetch_data    (fetch_data),
        .instr         (instr),
        .decode_en     (decode_en),
        .num_of_ope    (num_of_ope),
        .exec_en       (exec_en),
        .exec_done     (exec_done),
        .read_or_write (read_or_write),
        .write_data    (write_data),
        .retire        (retire),
        .eip           (eip),
        .fault         (fault),
        .halted        (halted)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] e,
                                               input int len,
                                               input logic [3:0] rw,
                                               input logic [31:0] wd);
        if (rw == 4'h4) return wd;
`ifdef JMP_REL_EN
        if (rw == 4'h5) return e + 32'(len) + wd;
`endif
        return e + 32'(len);
    endfunction

    // Executes one instruction starting from an observed FETCH cycle.
    task automatic run_instr(input int ack_dly, input int len,
                             input int done_dly, input logic [3:0] rw,
                             input logic [31:0] wd, input logic hreq);
        logic [31:0] d;
        int c0;
        d  = $urandom;
        c0 = cyc;
        chk("fetch_req", 32'(fetch_req), 32'd1);
        chk("fetch_addr", fetch_addr, eip_m);
        for (int k = 0; k < ack_dly; k++) begin
            fetch_ack  = 1'b0;
            fetch_data = $urandom;
            tick();
            chk("fetch_req_hold", 32'(fetch_req), 32'd1);
            chk("fetch_addr_hold", fetch_addr, eip_m);
        end
        fetch_ack  = 1'b1;
        fetch_data = d;
        tick();
        fetch_ack  = 1'b0;
        fetch_data = $urandom;
        chk("decode_en", 32'(decode_en), 32'd1);
        chk("instr", instr, d);
        chk("fetch_req_dec", 32'(fetch_req), 32'd0);
        num_of_ope    = 4'(len);
        read_or_write = 4'(($urandom & 1) ? 4 : 5);
        write_data    = $urandom;
        tick();
        num_of_ope = 4'($urandom);
        chk("decode_once", 32'(decode_en), 32'd0);
        if (!(len == 1 || len == 2 || len == 4)) begin
            chk("fault", 32'(fault), 32'd1);
            chk("halted_fault", 32'(halted), 32'd1);
            chk("retire_fault", 32'(retire), 32'd0);
            chk("eip_fault", eip, eip_m);
            return;
        end
        chk("fault_clear", 32'(fault), 32'd0);
        for (int k = 0; k < done_dly; k++) begin
            chk("exec_en_hold", 32'(exec_en), 32'd1);
            exec_done = 1'b0;
            tick();
        end
        chk("exec_en", 32'(exec_en), 32'd1);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("retire", 32'(retire), 32'd1);
        chk("eip_pre", eip, eip_m);
        if (ack_dly == 0 && done_dly == 0) chk("latency", 32'(cyc - c0), 32'd3);
        read_or_write = rw;
        write_data    = wd;
        halt_req      = hreq;
        tick();
        read_or_write = 4'($urandom);
        write_data    = $urandom;
        halt_req      = 1'b0;
        eip_m = model_next(eip_m, len, rw, wd);
        chk("eip", eip, eip_m);
        chk("retire_once", 32'(retire), 32'd0);
        if (hreq) begin
            chk("halted", 32'(halted), 32'd1);
            chk("fetch_req_halt", 32'(fetch_req), 32'd0);
        end else begin
            chk("next_fetch_req", 32'(fetch_req), 32'd1);
            chk("next_fetch_addr", fetch_addr, eip_m);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        eip_m = 32'h00000000;
    endtask

    initial begin
        logic [3:0] rw;
        int ln;
        reset = 1'b1; run = 1'b0; halt_req = 1'b0;
        fetch_ack = 1'b0; fetch_data = 32'd0; num_of_ope = 4'd0;
        exec_done = 1'b0; read_or_write = 4'd0; write_data = 32'd0;
        eip_m = 32'h00000000;
        tick();
        tick();
        chk("rst_eip", eip, 32'h00000000);
        chk("rst_fetch_req", 32'(fetch_req), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_instr", instr, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_no_fetch", 32'(fetch_req), 32'd0);
        end
        run = 1'b1;
        tick();

        run_instr(0, 2, 0, 4'h0, 32'h0, 1'b0);
        chk("eip_seq2", eip, 32'h00000002);
        run_instr(3, 1, 2, 4'h0, 32'h0, 1'b0);
        run_instr(0, 4, 0, 4'h4, 32'h00000100, 1'b0);
        chk("eip_abs", eip, 32'h00000100);
        run_instr(1, 2, 1, 4'h4, 32'hFFFFFFFE, 1'b0);
        run_instr(0, 4, 0, 4'h0, 32'h12345678, 1'b0);
        chk("eip_wrap", eip, 32'h00000002);
        run_instr(0, 1, 0, 4'h4, 32'h00000010, 1'b0);
        run_instr(0, 2, 0, 4'h5, 32'h00000020, 1'b0);
`ifdef JMP_REL_EN
        chk("eip_rel", eip, 32'h00000032);
`else
        chk("eip_rel_off", eip, 32'h00000012);
`endif

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: ln = 1;
                1: ln = 2;
                default: ln = 4;
            endcase
            case ($urandom_range(0, 3))
                0: rw = 4'h0;
                1: rw = 4'h4;
                2: rw = 4'h5;
                default: rw = 4'($urandom);
            endcase
            run_instr($urandom_range(0, 3), ln, $urandom_range(0, 3), rw,
                      $urandom, 1'b0);
        end

        run_instr(0, 2, 0, 4'h0, 32'h0, 1'b1);
        repeat (3) tick();
        chk("halt_stays", 32'(halted), 32'd1);
        chk("halt_no_fetch", 32'(fetch_req), 32'd0);

        do_reset();
        chk("post_halt_rst", 32'(halted), 32'd0);
        tick();
        run_instr(0, 3, 0, 4'h0, 32'h0, 1'b0);
        repeat (3) tick();
        chk("fault_sticky", 32'(fault), 32'd1);
        chk("fault_no_fetch", 32'(fetch_req), 32'd0);
        chk("fault_no_retire", 32'(retire), 32'd0);

        do_reset();
        chk("rst_fault_clr", 32'(fault), 32'd0);
        tick();
        run_instr(0, 4, 0, 4'h4, 32'h00000ABC, 1'b0);
        fetch_ack = 1'b0;
        tick();
        tick();
        chk("wait_ack", 32'(fetch_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run   = 1'b0;
        eip_m = 32'h00000000;
        chk("mid_rst_eip", eip, 32'h00000000);
        chk("mid_rst_fetch", 32'(fetch_req), 32'd0);
        tick();
        chk("mid_rst_idle", 32'(fetch_req), 32'd0);
        chk("mid_rst_halted", 32'(halted), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
